// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 32-bit ALU between two requesters.
// Round-robin grant, one operation in flight, registered operands and results.
// Optional build macro ALU_ZERO_FLAG_EN adds rsp0_zero/rsp1_zero result flags.
//
// Handshake rule for every channel here: a transfer happens on a rising clk edge
// where valid and ready are both high; valid never waits for ready, and the
// sender keeps its payload stable while valid is high and ready is low.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_f,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_r,
    output logic             rsp0_cout,
`ifdef ALU_ZERO_FLAG_EN
    output logic             rsp0_zero,
    output logic             rsp1_zero,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_f,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_r,
    output logic             rsp1_cout,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_f,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_cout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             prio_q;     // requester that wins a tie
    logic             gnt_q;      // requester owning the in-flight operation
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [OP_W-1:0]  op_f_q;
    logic [WIDTH-1:0] res0_r_q;
    logic [WIDTH-1:0] res1_r_q;
    logic             res0_cout_q;
    logic             res1_cout_q;
`ifdef ALU_ZERO_FLAG_EN
    logic             res0_zero_q;
    logic             res1_zero_q;
`endif

    logic any_req;
    logic sel;
    logic rsp_hs;

    // Grant choice: a lone requester wins, a tie goes to the priority pointer
    assign any_req = req0_valid | req1_valid;
    assign sel     = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign rsp_hs  = (state_q == S_RESP) & (gnt_q ? rsp1_ready : rsp0_ready);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: ready only in IDLE for the chosen requester, valid only in RESP for the owner
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        if (rst_n && state_q == S_IDLE && any_req) begin
            req0_ready = ~sel;
            req1_ready = sel;
        end
        if (state_q == S_RESP) begin
            rsp0_valid = ~gnt_q;
            rsp1_valid = gnt_q;
        end
    end

    // Operand latch on accept, result capture at end of EXEC, pointer flip on response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_f_q      <= '0;
            res0_r_q    <= '0;
            res1_r_q    <= '0;
            res0_cout_q <= 1'b0;
            res1_cout_q <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            res0_zero_q <= 1'b0;
            res1_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q  <= sel;
                        op_a_q <= sel ? req1_a : req0_a;
                        op_b_q <= sel ? req1_b : req0_b;
                        op_f_q <= sel ? req1_f : req0_f;
                    end
                end
                S_EXEC: begin
                    if (gnt_q) begin
                        res1_r_q    <= alu_r;
                        res1_cout_q <= alu_cout;
`ifdef ALU_ZERO_FLAG_EN
                        res1_zero_q <= (alu_r == '0);
`endif
                    end else begin
                        res0_r_q    <= alu_r;
                        res0_cout_q <= alu_cout;
`ifdef ALU_ZERO_FLAG_EN
                        res0_zero_q <= (alu_r == '0);
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_hs) prio_q <= ~gnt_q;
                end
                default: ;
            endcase
        end
    end

    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_f     = op_f_q;
    assign rsp0_r    = res0_r_q;
    assign rsp0_cout = res0_cout_q;
    assign rsp1_r    = res1_r_q;
    assign rsp1_cout = res1_cout_q;
`ifdef ALU_ZERO_FLAG_EN
    assign rsp0_zero = res0_zero_q;
    assign rsp1_zero = res1_zero_q;
`endif
    assign dbg_state = state_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU (A, B, F[2:0] -> R, Cout).
Each requester issues one operation through a valid/ready request channel and gets a registered result back on a valid/ready response channel.
Only one operation is in flight at a time.
Sits between the multi-cycle datapath units and the single ALU instance.

Parameters:
WIDTH, 32, operand/result width; must match the ALU instance.
OP_W, 3, function-select width; must match the ALU F port.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_f  input  OP_W  requester 0 function select
rsp0_valid  output  1  requester 0 result available
rsp0_ready  input  1  requester 0 takes result
rsp0_r  output  WIDTH  requester 0 result
rsp0_cout  output  1  requester 0 carry/borrow
req1_valid, req1_ready, req1_a, req1_b, req1_f, rsp1_valid, rsp1_ready, rsp1_r, rsp1_cout: same as requester 0, for requester 1
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_f  output  OP_W  to ALU F
alu_r  input  WIDTH  from ALU R
alu_cout  input  1  from ALU Cout

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE; priority pointer = requester 0.
  - Operand registers 0, so alu_a/alu_b/alu_f = 0.
  - Result registers 0; all req*_ready and rsp*_valid = 0.
- FSM, three states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester named by the priority pointer.
  - reqN_ready is combinational: high only in IDLE, only for the granted requester.
  - On the accepting edge, latch a/b/f into the operand registers and the grant ID, then go to EXEC.
  - If no request, stay in IDLE.
- EXEC: alu_a/alu_b/alu_f are driven from the operand registers (always registered, never straight from req ports). At the end of EXEC, capture alu_r and alu_cout into the result registers and go to RESP.
- RESP:
  - rspN_valid is high for the granted requester only; rspN_r and rspN_cout are the result registers.
  - Valid, r and cout stay stable until rspN_ready is sampled high.
  - On that handshake: go to IDLE and set the priority pointer to the other requester.
  - If rspN_ready is already high on the first RESP cycle, the response completes in that cycle.
- Latency: request accepted at edge T; rsp valid from edge T+2. Minimum issue interval is 3 cycles.
- While the FSM is not in IDLE, both req*_ready stay low. A requester that keeps reqN_valid high keeps its operands stable (standard valid/ready).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- The ungranted requester's rsp*_valid is always 0.
- rsp*_r and rsp*_cout hold their last captured value when not valid.
- The block does no arithmetic; R and Cout pass through from the ALU unmodified.
- The ALU function encoding is opaque to the block:
  - 000 add, Cout = carry.
  - 001 sub, Cout = borrow (B>A).
  - 010 and, 011 or, 100 xnor, 101 not A, 110 pass A, 111 not B; Cout = 0 for all of these.
- Reset mid-operation: any state returns immediately to IDLE and drops all valid/ready. The in-flight operation is discarded and is not replayed.

Optional Feature:
Macro ALU_ZERO_FLAG_EN.
- Defined: adds outputs rsp0_zero and rsp1_zero (1 bit each). Each is registered at the EXEC capture as (alu_r == 0), resets to 0, and follows the same valid/stability rules as rspN_r.
- Undefined: these ports and their logic do not exist.

Test Plan:
- Single add: req0 A=7FFFFFFF, B=00000001, F=000 accepted at T -> rsp0_valid at T+2, rsp0_r=80000000, rsp0_cout=0; req1_ready stays 0 throughout.
- Contention: both valid in the same cycle after reset -> req0 granted first. req1 (A=00000000, B=FFFFFFFF, F=001) is granted on the IDLE cycle after rsp0's handshake, then returns rsp1_r=00000001, rsp1_cout=1.
- Round-robin: both held valid for 6 operations -> grant order 0,1,0,1,0,1; each response matches its own operands.
- Backpressure: rsp1_ready held low 5 cycles after rsp1_valid with req1 F=011, A=B=7FFFFFFF -> rsp1_valid/r=7FFFFFFF held stable; req0_ready stays 0 until the handshake completes.
- Async reset: assert rst_n low mid-EXEC -> all valid/ready drop with no clk edge, alu_a/b/f=0; after release, req1 alone valid is granted normally.
- With ALU_ZERO_FLAG_EN: req0 A=80000000, B=00000000, F=010 -> rsp0_r=00000000, rsp0_zero=1; a following op with F=110, A=5 gives rsp0_zero=0.
